// File: rtl/systolic_mmu_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : systolic_mmu_stream
// Purpose  : NxN weight-stationary systolic matrix unit with streamed weight,
//            data and result handshakes, internal skew/de-skew and global stall.
//            Optional output clamp to 2^DW-1 when SYSTOLIC_SAT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module systolic_mmu_stream #(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int ACCW = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wt_valid,
  output logic              wt_ready,
  input  logic [N*DW-1:0]   wt_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [N*DW-1:0]   data_in,
  input  logic              data_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*ACCW-1:0] out_data,
  output logic              busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_wt_cnt, w_wt_cnt_nxt;
  logic            w_stall, w_wt_acc, w_dat_acc, w_pipe_empty;
  logic [2*N-2:0]  r_vld;
  logic            r_out_valid;
  logic [N*ACCW-1:0] r_out_data;

  logic [DW-1:0]   r_w     [N][N];
  logic [DW-1:0]   r_x     [N][N-1];
  logic [ACCW-1:0] r_ps    [N][N];
  logic [DW-1:0]   w_xin   [N];
  logic [DW-1:0]   w_pe_x  [N][N];
  logic [ACCW-1:0] w_pe_ps [N][N];
  logic [ACCW-1:0] w_dsk   [N];
  logic [ACCW-1:0] w_lane  [N];

  assign w_stall      = r_out_valid & ~out_ready;
  assign w_wt_acc     = wt_valid & wt_ready;
  assign w_dat_acc    = data_valid & data_ready;
  assign w_pipe_empty = ~(|r_vld) & ~r_out_valid;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_wt_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wt_cnt <= w_wt_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wt_cnt_nxt = r_wt_cnt;
    wt_ready     = 1'b0;
    data_ready   = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        wt_ready = 1'b1;
        if (wt_valid) begin
          w_state_nxt  = ST_LOAD;
          w_wt_cnt_nxt = CW'(1);
        end
      end
      ST_LOAD: begin
        wt_ready = 1'b1;
        busy     = 1'b1;
        if (wt_valid) begin
          if (r_wt_cnt == CW'(N - 1)) begin
            w_state_nxt  = ST_READY;
            w_wt_cnt_nxt = '0;
          end else begin
            w_wt_cnt_nxt = r_wt_cnt + CW'(1);
          end
        end
      end
      ST_READY: begin
        // Data has priority: a pending vector blocks any weight reload.
        wt_ready   = ~data_valid;
        data_ready = ~w_stall;
        if (data_valid) begin
          if (!w_stall && data_last) w_state_nxt = ST_DRAIN;
        end else if (wt_valid) begin
          w_state_nxt  = ST_LOAD;
          w_wt_cnt_nxt = CW'(1);
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (w_pipe_empty) w_state_nxt = ST_READY;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Weights enter at row 0 and shift one row down per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) r_w[r][c] <= '0;
    end else if (w_wt_acc) begin
      for (int c = 0; c < N; c++) begin
        r_w[0][c] <= wt_in[c*DW +: DW];
        for (int r = 1; r < N; r++) r_w[r][c] <= r_w[r-1][c];
      end
    end
  end

  genvar gr, gc;
  generate
    for (gr = 0; gr < N; gr++) begin : g_skew
      if (gr == 0) begin : g_direct
        assign w_xin[gr] = data_in[0 +: DW];
      end else begin : g_dly
        logic [DW-1:0] r_sk [gr];
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int i = 0; i < gr; i++) r_sk[i] <= '0;
          end else if (!w_stall) begin
            r_sk[0] <= data_in[gr*DW +: DW];
            for (int i = 1; i < gr; i++) r_sk[i] <= r_sk[i-1];
          end
        end
        assign w_xin[gr] = r_sk[gr-1];
      end
    end

    for (gr = 0; gr < N; gr++) begin : g_pe_row
      for (gc = 0; gc < N; gc++) begin : g_pe_col
        if (gc == 0) begin : g_xl
          assign w_pe_x[gr][gc] = w_xin[gr];
        end else begin : g_xi
          assign w_pe_x[gr][gc] = r_x[gr][gc-1];
        end
        if (gr == 0) begin : g_pt
          assign w_pe_ps[gr][gc] = '0;
        end else begin : g_pi
          assign w_pe_ps[gr][gc] = r_ps[gr-1][gc];
        end
      end
    end

    for (gc = 0; gc < N; gc++) begin : g_deskew
      if (gc == N - 1) begin : g_direct
        assign w_dsk[gc] = r_ps[N-1][gc];
      end else begin : g_dly
        logic [ACCW-1:0] r_ds [N-1-gc];
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int i = 0; i < N - 1 - gc; i++) r_ds[i] <= '0;
          end else if (!w_stall) begin
            r_ds[0] <= r_ps[N-1][gc];
            for (int i = 1; i < N - 1 - gc; i++) r_ds[i] <= r_ds[i-1];
          end
        end
        assign w_dsk[gc] = r_ds[N-2-gc];
      end
    end

`ifdef SYSTOLIC_SAT_EN
    localparam logic [ACCW-1:0] SAT_MAX = {{(ACCW-DW){1'b0}}, {DW{1'b1}}};
    for (gc = 0; gc < N; gc++) begin : g_sat
      assign w_lane[gc] = (w_dsk[gc] > SAT_MAX) ? SAT_MAX : w_dsk[gc];
    end
`else
    for (gc = 0; gc < N; gc++) begin : g_full
      assign w_lane[gc] = w_dsk[gc];
    end
`endif
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) r_ps[r][c] <= '0;
        for (int c = 0; c < N - 1; c++) r_x[r][c] <= '0;
      end
    end else if (!w_stall) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++)
          r_ps[r][c] <= w_pe_ps[r][c] +
                        ACCW'({{DW{1'b0}}, w_pe_x[r][c]} * {{DW{1'b0}}, r_w[r][c]});
        for (int c = 0; c < N - 1; c++) r_x[r][c] <= w_pe_x[r][c];
      end
    end
  end

  // Valid bit marches alongside the wavefront; output only updates on a real result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (!w_stall) begin
      r_vld       <= {r_vld[2*N-3:0], w_dat_acc};
      r_out_valid <= r_vld[2*N-2];
      if (r_vld[2*N-2]) begin
        for (int c = 0; c < N; c++) r_out_data[c*ACCW +: ACCW] <= w_lane[c];
      end
    end
  end

endmodule
`default_nettype wire
